// File: rtl/axis_combine_if.sv
// N-slot AXI-Stream join bundle: N slave lanes in, one concatenated master out.
// master drives the lanes and m_axis_tready; slave is the join block's view.
interface axis_combine_if #(
  parameter int C_AXIS_TDATA_WIDTH = 16,
  parameter int C_NUM_SI_SLOTS     = 4
);
  localparam int W = C_AXIS_TDATA_WIDTH;
  localparam int N = C_NUM_SI_SLOTS;

  logic         s_axis_tvalid [N];
  logic         s_axis_tready [N];
  logic [W-1:0] s_axis_tdata  [N];

  logic           m_axis_tvalid;
  logic           m_axis_tready;
  logic [N*W-1:0] m_axis_tdata;

  modport master (
    output s_axis_tvalid,
    output s_axis_tdata,
    input  s_axis_tready,
    input  m_axis_tvalid,
    input  m_axis_tdata,
    output m_axis_tready
  );

  modport slave (
    input  s_axis_tvalid,
    input  s_axis_tdata,
    output s_axis_tready,
    output m_axis_tvalid,
    output m_axis_tdata,
    input  m_axis_tready
  );
endinterface

// File: rtl/axis_combine.sv
// N-to-1 AXI-Stream join: one 1-deep holding register per lane, one
// registered output beat carrying all lane payloads (lane 0 in the LSBs).
module axis_combine #(
  parameter int C_AXIS_TDATA_WIDTH = 16,
  parameter int C_NUM_SI_SLOTS     = 4
) (
  input  logic          aclk,
  input  logic          aresetn,
  axis_combine_if.slave axis,
  output logic [31:0]   m_beat_count
);
  localparam int W = C_AXIS_TDATA_WIDTH;
  localparam int N = C_NUM_SI_SLOTS;

  logic [N-1:0]   hold_full;
  logic [W-1:0]   hold_data [N];
  logic [N-1:0]   cap;
  logic [N*W-1:0] join_data;
  logic [N*W-1:0] out_data;
  logic           out_valid;
  logic           join_fire;
  logic           m_hs;
  logic [31:0]    beat_cnt;

  // A full output that is draining frees room for a new join this edge.
  assign join_fire = (&hold_full) & (~out_valid | axis.m_axis_tready);
  assign m_hs      = out_valid & axis.m_axis_tready;

  for (genvar i = 0; i < N; i++) begin : g_slot
    assign axis.s_axis_tready[i] =
      aresetn & (~hold_full[i] | join_fire);
    assign cap[i] =
      axis.s_axis_tvalid[i] & axis.s_axis_tready[i];
    assign join_data[i*W +: W] = hold_data[i];
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      hold_full <= '0;
      for (int i = 0; i < N; i++) begin
        hold_data[i] <= '0;
      end
    end else begin
      for (int i = 0; i < N; i++) begin
        if (cap[i]) begin
          hold_data[i] <= axis.s_axis_tdata[i];
          hold_full[i] <= 1'b1;
        end else if (join_fire) begin
          hold_full[i] <= 1'b0;
        end
      end
    end
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      beat_cnt  <= '0;
    end else begin
      if (join_fire) begin
        out_valid <= 1'b1;
        out_data  <= join_data;
      end else if (m_hs) begin
        out_valid <= 1'b0;
      end
      if (m_hs) begin
        beat_cnt <= beat_cnt + 32'd1;
      end
    end
  end

  assign axis.m_axis_tvalid = out_valid;
  assign axis.m_axis_tdata  = out_data;
  assign m_beat_count       = beat_cnt;
endmodule

// File: tb/tb_axis_combine.sv
// Bench for axis_combine: per-lane source queues, a join model built from
// lane queues, and a scoreboard of expected concatenated beats.
module tb_axis_combine;
  localparam int W = 16;
  localparam int N = 4;

  logic        aclk = 1'b0;
  logic        aresetn = 1'b0;
  logic [31:0] m_beat_count;

  axis_combine_if #(
    .C_AXIS_TDATA_WIDTH(W),
    .C_NUM_SI_SLOTS(N)
  ) bus ();

  axis_combine #(
    .C_AXIS_TDATA_WIDTH(W),
    .C_NUM_SI_SLOTS(N)
  ) dut (
    .aclk(aclk),
    .aresetn(aresetn),
    .axis(bus.slave),
    .m_beat_count(m_beat_count)
  );

  always #5 aclk = ~aclk;

  int             tests = 0;
  int             fails = 0;
  logic [W-1:0]   src_q [N][$];
  logic [W-1:0]   mdl_q [N][$];
  logic [N*W-1:0] exp_q [$];
  logic           acc [N];
  int             duty [N];
  int             rdy_duty = 100;
  int             hs_total = 0;
  logic           pv, pr;
  logic [N*W-1:0] pd;
  logic [N*W-1:0] cat;
  bit             all_have;

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  function automatic logic [N-1:0] rdy_vec();
    logic [N-1:0] r;
    for (int i = 0; i < N; i++) r[i] = bus.s_axis_tready[i];
    return r;
  endfunction

  function automatic logic [N*W-1:0] beat_of(input logic [W-1:0] base,
                                             input int k);
    logic [N*W-1:0] v;
    for (int i = 0; i < N; i++)
      v[i*W +: W] = base + W'(16 * k + i);
    return v;
  endfunction

  // Lane and downstream drivers: valid holds until accepted.
  always @(posedge aclk) begin
    #1;
    for (int i = 0; i < N; i++) begin
      bit took;
      took = (acc[i] === 1'b1);
      if (took && src_q[i].size() > 0) src_q[i].delete(0);
      if (!aresetn || src_q[i].size() == 0) begin
        bus.s_axis_tvalid[i] = 1'b0;
        bus.s_axis_tdata[i]  = '0;
      end else begin
        if (bus.s_axis_tvalid[i] !== 1'b1 || took)
          bus.s_axis_tvalid[i] = ($urandom_range(99) < duty[i]);
        bus.s_axis_tdata[i] = src_q[i][0];
      end
    end
    bus.m_axis_tready = ($urandom_range(99) < rdy_duty);
  end

  // Monitor: records lane handshakes, forms expected joins, checks output.
  always @(negedge aclk) begin
    if (!aresetn) begin
      for (int i = 0; i < N; i++) begin
        mdl_q[i].delete();
        acc[i] = 1'b0;
      end
      exp_q.delete();
      pv = 1'b0;
    end else begin
      if (pv && !pr) begin
        chk("stall_valid", 64'(bus.m_axis_tvalid), 64'd1);
        chk("stall_data", bus.m_axis_tdata, pd);
      end
      if (bus.m_axis_tvalid && bus.m_axis_tready) begin
        hs_total++;
        if (exp_q.size() == 0) begin
          chk("beat_expected", 64'd0, 64'd1);
        end else begin
          chk("beat_data", bus.m_axis_tdata, exp_q.pop_front());
        end
      end
      for (int i = 0; i < N; i++) begin
        acc[i] = bus.s_axis_tvalid[i] & bus.s_axis_tready[i];
        if (acc[i]) mdl_q[i].push_back(bus.s_axis_tdata[i]);
      end
      all_have = 1'b1;
      for (int i = 0; i < N; i++)
        if (mdl_q[i].size() == 0) all_have = 1'b0;
      if (all_have) begin
        for (int i = 0; i < N; i++)
          cat[i*W +: W] = mdl_q[i].pop_front();
        exp_q.push_back(cat);
      end
      pv = bus.m_axis_tvalid;
      pr = bus.m_axis_tready;
      pd = bus.m_axis_tdata;
    end
  end

  task automatic step(input int n);
    repeat (n) @(posedge aclk);
    #2;
  endtask

  task automatic do_reset();
    @(negedge aclk);
    #1;
    aresetn = 1'b0;
    for (int i = 0; i < N; i++) src_q[i].delete();
    step(2);
    @(negedge aclk);
    #1;
    aresetn = 1'b1;
    step(1);
  endtask

  function automatic bit busy();
    bit b;
    b = (exp_q.size() != 0) || bus.m_axis_tvalid;
    for (int i = 0; i < N; i++)
      if (src_q[i].size() != 0 || mdl_q[i].size() != 0) b = 1'b1;
    return b;
  endfunction

  task automatic drain(input string nm, input int budget);
    int n;
    n = 0;
    while (busy() && n < budget) begin
      @(posedge aclk);
      n++;
    end
    #2;
    chk(nm, 64'(n < budget), 64'd1);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < N; i++) duty[i] = 100;
    aresetn = 1'b0;
    step(3);
    chk("rst_valid", 64'(bus.m_axis_tvalid), 64'd0);
    chk("rst_data", bus.m_axis_tdata, 64'd0);
    chk("rst_count", 64'(m_beat_count), 64'd0);
    chk("rst_ready", 64'(rdy_vec()), 64'd0);
    @(negedge aclk);
    #1;
    aresetn = 1'b1;
    step(1);
    chk("rel_ready", 64'(rdy_vec()), 64'hF);

    // Reset in the middle of a stalled stream
    @(negedge aclk);
    for (int k = 0; k < 5; k++)
      for (int i = 0; i < N; i++) src_q[i].push_back(16'hC000 + 16'(k*16+i));
    step(5);
    chk("mid_count", 64'(m_beat_count), 64'd2);
    @(negedge aclk);
    rdy_duty = 0;
    step(2);
    @(negedge aclk);
    #1;
    aresetn = 1'b0;
    for (int i = 0; i < N; i++) src_q[i].delete();
    #1;
    chk("mid_rst_valid", 64'(bus.m_axis_tvalid), 64'd0);
    chk("mid_rst_data", bus.m_axis_tdata, 64'd0);
    chk("mid_rst_ready", 64'(rdy_vec()), 64'd0);
    chk("mid_rst_count", 64'(m_beat_count), 64'd0);
    @(negedge aclk);
    #1;
    aresetn = 1'b1;
    rdy_duty = 100;
    step(1);
    chk("mid_rel_ready", 64'(rdy_vec()), 64'hF);

    // Aligned join
    @(negedge aclk);
    for (int i = 0; i < N; i++) src_q[i].push_back(16'h1111 * 16'(i + 1));
    step(3);
    chk("align_valid", 64'(bus.m_axis_tvalid), 64'd1);
    chk("align_data", bus.m_axis_tdata, 64'h4444_3333_2222_1111);
    step(1);
    chk("align_valid_off", 64'(bus.m_axis_tvalid), 64'd0);
    chk("align_count", 64'(m_beat_count), 64'd1);

    // Skewed lanes
    @(negedge aclk);
    for (int i = 0; i < 3; i++) src_q[i].push_back(16'hA000 + 16'(i));
    step(2);
    chk("skew_ready", 64'(rdy_vec()), 64'b1000);
    step(3);
    @(negedge aclk);
    src_q[3].push_back(16'hA003);
    step(1);
    chk("skew_c5", 64'(bus.m_axis_tvalid), 64'd0);
    step(1);
    chk("skew_c6", 64'(bus.m_axis_tvalid), 64'd0);
    step(1);
    chk("skew_c7", 64'(bus.m_axis_tvalid), 64'd1);
    chk("skew_data", bus.m_axis_tdata, 64'hA003_A002_A001_A000);
    drain("skew_drain", 50);

    // Backpressure over a 3-beat stream
    @(negedge aclk);
    rdy_duty = 0;
    for (int k = 0; k < 3; k++)
      for (int i = 0; i < N; i++) src_q[i].push_back(16'hB000 + 16'(k*16+i));
    step(11);
    chk("bp_valid", 64'(bus.m_axis_tvalid), 64'd1);
    chk("bp_data", bus.m_axis_tdata, beat_of(16'hB000, 0));
    chk("bp_ready", 64'(rdy_vec()), 64'd0);
    @(negedge aclk);
    rdy_duty = 100;
    drain("bp_drain", 100);
    chk("bp_count", 64'(m_beat_count), 64'd5);

    // Random streaming, 1000 beats per lane
    do_reset();
    @(negedge aclk);
    for (int i = 0; i < N; i++) begin
      duty[i] = $urandom_range(100, 30);
      for (int k = 0; k < 1000; k++) src_q[i].push_back(W'($urandom));
    end
    rdy_duty = $urandom_range(100, 30);
    drain("rand_drain", 40000);
    chk("rand_count", 64'(m_beat_count), 64'd1000);

    // Sustained full-rate throughput
    @(negedge aclk);
    rdy_duty = 100;
    for (int i = 0; i < N; i++) begin
      duty[i] = 100;
      for (int k = 0; k < 200; k++) src_q[i].push_back(W'($urandom));
    end
    step(6);
    begin
      int h0;
      h0 = hs_total;
      step(150);
      chk("tput", 64'(hs_total - h0), 64'd150);
    end
    drain("tput_drain", 500);

    // Counter wrap
    do_reset();
    @(negedge aclk);
    force dut.beat_cnt = 32'hFFFF_FFFE;
    #1;
    release dut.beat_cnt;
    chk("wrap_pre", 64'(m_beat_count), 64'hFFFF_FFFE);
    for (int k = 0; k < 2; k++)
      for (int i = 0; i < N; i++) src_q[i].push_back(16'hD000 + 16'(k*16+i));
    step(4);
    chk("wrap_ff", 64'(m_beat_count), 64'hFFFF_FFFF);
    step(1);
    chk("wrap_zero", 64'(m_beat_count), 64'd0);
    drain("wrap_drain", 50);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
